sram_arbiter: RTL
=================

# sram_arbiter

Arbitrates the single on-chip SRAM port among NUM_REQ pixel-datapath requesters: port 0 is frame readout; ports 1..NUM_REQ-1 are the fill and line/draw blocks. The arbiter sits between the requesters and the SRAM wrapper. It serialises their read and write accesses, holds each access for the fixed SRAM access window, and returns a one-cycle acknowledge together with the captured read data. This replaces the point-to-point link between the fill block and the SRAM.

## Interface
- ADDR_SIZE_BITS, 24: SRAM address width.
- WORD_SIZE_BYTES, 3: bytes per pixel word.
- DATA_SIZE_WORDS, 64: words per SRAM line. DATA_W = WORD_SIZE_BYTES*DATA_SIZE_WORDS*8 (1536).
- NUM_REQ, 3: number of requesters, 2..8.
- ACCESS_CYCLES, 2: cycles that the SRAM enables are held per access, ≥1.
- PRIO0, 1: 1 gives port 0 absolute priority; 0 puts all ports in round-robin.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  per-port access request, level signal.
- we  in  NUM_REQ  per-port write (1) or read (0). Valid while req is high.
- addr  in  NUM_REQ×ADDR_SIZE_BITS  per-port address.
- wdata  in  NUM_REQ×DATA_W  per-port write data.
- ack  out  NUM_REQ  one-hot, one-cycle access-complete pulse.
- rdata  out  DATA_W  read data, registered. Valid in the ack cycle.
- busy  out  1  high in ACCESS and ACK states.
- grant_id  out  $clog2(NUM_REQ)  port currently or last granted.
- read_enable, write_enable  out  1 each  SRAM strobes.
- address  out  ADDR_SIZE_BITS  SRAM address.
- write_data  out  DATA_W  SRAM write data.
- read_data  in  DATA_W  SRAM read data.

## Operation
- State machine states:
  - IDLE → ACCESS when any bit of req is high. The arbiter selects the winner, latches its index, we, addr and wdata, and loads the counter with ACCESS_CYCLES-1.
  - ACCESS holds the SRAM strobe for the latched type, plus address and write_data, from the latched values. It decrements the counter and goes to ACK when the counter is 0. On the final ACCESS cycle for a read, rdata is loaded from read_data.
  - ACK pulses ack[grant_id] for exactly one cycle, then returns to IDLE. Strobes are low in ACK.
- Selection rules:
  - If PRIO0=1 and req[0] is high, port 0 wins.
  - Otherwise the winner is the first requesting port, searching upward from (rr_ptr+1) mod NUM_REQ.
  - rr_ptr updates to the winner's index on every grant, including port-0 grants.
- Requester protocol:
  - A requester holds req, we, addr and wdata stable until it sees ack, and drops req in the cycle after ack unless it needs another access.
  - Inputs are latched at grant, so later changes to the inputs have no effect on the current access.
  - If req drops mid-access, the access still completes and ack still pulses.
- Outputs:
  - When the arbiter is not in ACCESS, read_enable=write_enable=0, and address and write_data hold their last values.
  - read_enable and write_enable are never high together.
  - rdata holds its value until the next read completes. Writes do not change rdata.

## Timing
- Reset values: ack=0, read_enable=0, write_enable=0, busy=0, grant_id=0, rr_ptr=NUM_REQ-1 (so port 0 wins first), address=0, write_data=0, rdata=0, state=IDLE.
- Latency: req high in IDLE at cycle t gives strobes in cycles t+1..t+ACCESS_CYCLES and ack in cycle t+ACCESS_CYCLES+1. The earliest next grant decision is at t+ACCESS_CYCLES+2. Peak rate is one access per ACCESS_CYCLES+2 cycles.
- A request arriving during ACCESS or ACK waits. It has no effect until IDLE.
- Simultaneous requests are resolved in the same IDLE cycle using the rules above.
- Reset asserted mid-operation: all strobes and ack are 0 at the next edge and the state returns to IDLE. The in-flight access is abandoned and no ack is issued.

## Structure
- sram_arb_pkg holds:
  - the state enum (IDLE, ACCESS, ACK);
  - the DATA_W derivation function;
  - the port-index localparams (FRAME_PORT=0, FILL_PORT=1, LINE_PORT=2).
- One sub-module, rr_select. It is purely combinational: inputs are req, rr_ptr and PRIO0; output is the winner index plus a found flag.
- Counter, latches and state machine stay in sram_arbiter.

## Test plan
- Reset then single write: req[1]=1, we=1, addr=24'h000010, wdata=all 24'hFF0000. Required: write_enable high at cycles 1–2 with address 0x10; ack[1] at cycle 3; memory dump shows the line.
- Read-back: port 2 reads 0x10. Required: read_enable for 2 cycles; ack[2] with rdata equal to the written pattern; rdata unchanged after a following write.
- Round-robin: PRIO0=0, req=3'b110 held continuously. Required: grants alternate 1,2,1,2; no port receives two consecutive acks.
- Priority: PRIO0=1, req=3'b111. Required: port 0 is granted every arbitration while req[0] is held; ports 1 and 2 resume round-robin after req[0] drops.
- Input change mid-access: port 1 changes addr from 0x20 to 0x30 during ACCESS. Required: the SRAM sees only 0x20 and ack is still issued.
- Reset during ACCESS (cycle 2 of a write): required: strobes=0 and ack=0 on the next edge, state IDLE; a new request is served normally afterwards.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam int unsigned FRAME_PORT = 0;
    localparam int unsigned FILL_PORT  = 1;
    localparam int unsigned LINE_PORT  = 2;

    // SRAM line width in bits.
    function automatic int unsigned data_w(input int unsigned word_bytes,
                                           input int unsigned words);
        return word_bytes * words * 8;
    endfunction

endpackage

// File: rtl/sram_arb_rr_select.sv
// Winner selection: optional fixed priority for the frame port, else round-robin
// searching upward from the port after the last grant.
module rr_select
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter bit          PRIO0   = 1'b1,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);

    always_comb begin
        winner = '0;
        found  = 1'b0;
        if (PRIO0 && req[FRAME_PORT]) begin
            winner = IDX_W'(FRAME_PORT);
            found  = 1'b1;
        end else begin
            for (int unsigned i = 1; i <= NUM_REQ; i++) begin
                if (!found && req[IDX_W'((32'(rr_ptr) + i) % NUM_REQ)]) begin
                    winner = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Serialises NUM_REQ requesters onto the single SRAM port: grant, hold strobes for
// ACCESS_CYCLES, then a one-cycle ack with the captured read data.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned  ADDR_SIZE_BITS  = 24,
    parameter int unsigned  WORD_SIZE_BYTES = 3,
    parameter int unsigned  DATA_SIZE_WORDS = 64,
    parameter int unsigned  NUM_REQ         = 3,
    parameter int unsigned  ACCESS_CYCLES   = 2,
    parameter bit           PRIO0           = 1'b1,
    localparam int unsigned DATA_W          = data_w(WORD_SIZE_BYTES, DATA_SIZE_WORDS),
    localparam int unsigned IDX_W           = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          we,
    input  logic [NUM_REQ*ADDR_SIZE_BITS-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic [IDX_W-1:0]            grant_id,
    output logic                        read_enable,
    output logic                        write_enable,
    output logic [ADDR_SIZE_BITS-1:0]   address,
    output logic [DATA_W-1:0]           write_data,
    input  logic [DATA_W-1:0]           read_data
);

    localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    state_t                    state, state_d;
    logic [CNT_W-1:0]          cnt, cnt_d;
    logic [IDX_W-1:0]          rr_ptr, rr_d, grant_d;
    logic [IDX_W-1:0]          winner;
    logic                      found;
    logic [NUM_REQ-1:0]        ack_d;
    logic [DATA_W-1:0]         rdata_d, write_data_d;
    logic [ADDR_SIZE_BITS-1:0] address_d;
    logic                      busy_d, rd_en_d, wr_en_d;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .PRIO0   (PRIO0),
        .IDX_W   (IDX_W)
    ) u_sel (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .found  (found)
    );

    // Next-state and next-output logic; address/write_data double as the grant latches.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        rr_d         = rr_ptr;
        grant_d      = grant_id;
        address_d    = address;
        write_data_d = write_data;
        rdata_d      = rdata;
        ack_d        = '0;
        busy_d       = 1'b0;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_d      = ACCESS;
                    cnt_d        = CNT_W'(ACCESS_CYCLES - 1);
                    rr_d         = winner;
                    grant_d      = winner;
                    address_d    = addr[32'(winner)*ADDR_SIZE_BITS +: ADDR_SIZE_BITS];
                    write_data_d = wdata[32'(winner)*DATA_W +: DATA_W];
                    wr_en_d      = we[winner];
                    rd_en_d      = ~we[winner];
                    busy_d       = 1'b1;
                end
            end
            ACCESS: begin
                busy_d = 1'b1;
                if (cnt == '0) begin
                    state_d         = ACK;
                    ack_d[grant_id] = 1'b1;
                    if (read_enable) begin
                        rdata_d = read_data;
                    end
                end else begin
                    cnt_d   = cnt - CNT_W'(1);
                    rd_en_d = read_enable;
                    wr_en_d = write_enable;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rr_ptr       <= IDX_W'(NUM_REQ - 1);
            grant_id     <= '0;
            address      <= '0;
            write_data   <= '0;
            rdata        <= '0;
            ack          <= '0;
            busy         <= 1'b0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            rr_ptr       <= rr_d;
            grant_id     <= grant_d;
            address      <= address_d;
            write_data   <= write_data_d;
            rdata        <= rdata_d;
            ack          <= ack_d;
            busy         <= busy_d;
            read_enable  <= rd_en_d;
            write_enable <= wr_en_d;
        end
    end

endmodule
